// File: rtl/alu_req_scheduler_if.sv
// Bundle of requester, ALU-side and response signals for alu_req_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface alu_req_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_opcode;
    logic [15:0] req0_a;
    logic [15:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_opcode;
    logic [15:0] req1_a;
    logic [15:0] req1_b;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_opcode,
        output rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_opcode,
        input  rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational 16-bit ALU between two
// requesters; one operation in flight, operands held in registers while it runs.
module alu_req_scheduler #(
    parameter int MUL_CYCLES = 3,
    parameter int OP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_req_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL     = 3'b001;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    localparam int MAX_CYCLES = (MUL_CYCLES > OP_CYCLES) ? MUL_CYCLES : OP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [15:0]        alu_a_q, alu_a_d;
    logic [15:0]        alu_b_q, alu_b_d;
    logic [2:0]         alu_opcode_q, alu_opcode_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_any;
    logic               grant_id;
    logic [2:0]         sel_opcode;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;

    // A contested cycle goes to whoever did not win last time.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
        sel_opcode = grant_id ? bus.req1_opcode : bus.req0_opcode;
        sel_a      = grant_id ? bus.req1_a      : bus.req0_a;
        sel_b      = grant_id ? bus.req1_b      : bus.req0_b;
    end

    assign bus.req0_ready = (state_q == IDLE) && grant_any && !grant_id;
    assign bus.req1_ready = (state_q == IDLE) && grant_any &&  grant_id;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_opcode_d = sel_opcode;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    if (sel_opcode == OP_ILLEGAL) begin
                        rsp_result_d = 32'h0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = (sel_opcode == OP_MUL) ? CNT_W'(MUL_CYCLES - 1)
                                                         : CNT_W'(OP_CYCLES - 1);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_result_d = bus.alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    alu_opcode_d = OP_ILLEGAL;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            alu_a_q      <= 16'h0;
            alu_b_q      <= 16'h0;
            alu_opcode_q <= OP_ILLEGAL;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: directed scenarios followed by
// random traffic, checked against a transaction-level round-robin/latency model.
module tb_alu_req_scheduler;

   localparam int MUL_CYCLES = 3;
   localparam int OP_CYCLES  = 1;

   logic clk = 1'b0;
   logic rst;
   int   testsRun    = 0;
   int   testsFailed = 0;
   logic mdlLastGrant;

   always #5 clk = ~clk;

   alu_req_scheduler_if bus ();

   alu_req_scheduler #(
      .MUL_CYCLES(MUL_CYCLES),
      .OP_CYCLES (OP_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Arithmetic meaning of each opcode, used both as the external ALU and as the reference
   function automatic logic [31:0] aluFn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] za;
      logic [31:0] zb;
      za = {16'h0, a};
      zb = {16'h0, b};
      case (op)
         3'b000:  return za + zb;
         3'b001:  return za * zb;
         3'b010:  return za - zb;
         3'b011:  return za & zb;
         3'b100:  return za | zb;
         3'b101:  return za ^ zb;
         3'b110:  return {16'h0, ~a};
         default: return 32'h0;
      endcase
   endfunction

   assign bus.alu_result = aluFn(bus.alu_opcode, bus.alu_a, bus.alu_b);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                                input logic v1, input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1);
      bus.req0_valid  = v0;
      bus.req0_opcode = op0;
      bus.req0_a      = a0;
      bus.req0_b      = b0;
      bus.req1_valid  = v1;
      bus.req1_opcode = op1;
      bus.req1_a      = a1;
      bus.req1_b      = b1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".alu_a"},      bus.alu_a,      32'h0);
      checkOutput({tag, ".alu_b"},      bus.alu_b,      32'h0);
      checkOutput({tag, ".alu_opcode"}, bus.alu_opcode, 32'h7);
      checkOutput({tag, ".rsp_valid"},  bus.rsp_valid,  32'h0);
      checkOutput({tag, ".rsp_id"},     bus.rsp_id,     32'h0);
      checkOutput({tag, ".rsp_result"}, bus.rsp_result, 32'h0);
      checkOutput({tag, ".rsp_err"},    bus.rsp_err,    32'h0);
      checkOutput({tag, ".busy"},       bus.busy,       32'h0);
   endtask

   // One whole transaction: offer requests, expect the model's winner, follow it to response handshake
   task automatic doOp(input string tag,
                       input logic v0, input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                       input int holdCycles, input logic holdValid,
                       output logic gotId, output logic [31:0] gotRes, output logic gotErr);
      logic        winner;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] expRes;
      int          lat;

      applyStimulus(v0, op0, a0, b0, v1, op1, a1, b1);
      #1;
      winner = (v0 && v1) ? ~mdlLastGrant : v1;
      op     = winner ? op1 : op0;
      a      = winner ? a1 : a0;
      b      = winner ? b1 : b0;
      expRes = (op == 3'b111) ? 32'h0 : aluFn(op, a, b);
      lat    = (op == 3'b001) ? MUL_CYCLES : OP_CYCLES;
      checkOutput({tag, ".ready0"}, bus.req0_ready, {31'h0, !winner});
      checkOutput({tag, ".ready1"}, bus.req1_ready, {31'h0, winner});
      tick();
      mdlLastGrant = winner;
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0);

      if (op != 3'b111) begin
         for (int i = 0; i < lat; i++) begin
            #1;
            checkOutput({tag, ".exec.rsp_valid"},  bus.rsp_valid,  32'h0);
            checkOutput({tag, ".exec.busy"},       bus.busy,       32'h1);
            checkOutput({tag, ".exec.alu_opcode"}, bus.alu_opcode, {29'h0, op});
            checkOutput({tag, ".exec.alu_a"},      bus.alu_a,      {16'h0, a});
            checkOutput({tag, ".exec.alu_b"},      bus.alu_b,      {16'h0, b});
            tick();
         end
      end

      checkOutput({tag, ".rsp_valid"},  bus.rsp_valid,  32'h1);
      checkOutput({tag, ".rsp_id"},     bus.rsp_id,     {31'h0, winner});
      checkOutput({tag, ".rsp_result"}, bus.rsp_result, expRes);
      checkOutput({tag, ".rsp_err"},    bus.rsp_err,    {31'h0, op == 3'b111});
      checkOutput({tag, ".alu_opcode"}, bus.alu_opcode, 32'h7);
      checkOutput({tag, ".alu_a_kept"}, bus.alu_a,      {16'h0, a});
      gotId  = bus.rsp_id;
      gotRes = bus.rsp_result;
      gotErr = bus.rsp_err;

      for (int h = 0; h < holdCycles; h++) begin
         applyStimulus(holdValid, 3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                       holdValid, 3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
         bus.rsp_ready = 1'b0;
         #1;
         checkOutput({tag, ".hold.ready0"}, bus.req0_ready, 32'h0);
         checkOutput({tag, ".hold.ready1"}, bus.req1_ready, 32'h0);
         tick();
         checkOutput({tag, ".hold.rsp_valid"},  bus.rsp_valid,  32'h1);
         checkOutput({tag, ".hold.rsp_id"},     bus.rsp_id,     {31'h0, winner});
         checkOutput({tag, ".hold.rsp_result"}, bus.rsp_result, expRes);
         checkOutput({tag, ".hold.rsp_err"},    bus.rsp_err,    {31'h0, op == 3'b111});
         checkOutput({tag, ".hold.busy"},       bus.busy,       32'h1);
      end

      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput({tag, ".done.rsp_valid"}, bus.rsp_valid, 32'h0);
      checkOutput({tag, ".done.busy"},      bus.busy,      32'h0);
   endtask

   initial begin
      logic        gotId;
      logic [31:0] gotRes;
      logic        gotErr;
      logic        v0;
      logic        v1;

      rst = 1'b1;
      bus.rsp_ready = 1'b0;
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0);
      mdlLastGrant = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkResetState("reset");
      checkOutput("reset.ready0", bus.req0_ready, 32'h0);
      checkOutput("reset.ready1", bus.req1_ready, 32'h0);
      tick();

      doOp("add", 1'b1, 3'b000, 16'h0005, 16'h0003, 1'b0, 3'b000, 16'h0, 16'h0, 0, 1'b0, gotId, gotRes, gotErr);
      checkOutput("add.lit_res", gotRes, 32'h0000_0008);
      checkOutput("add.lit_id",  gotId,  32'h0);

      doOp("mul", 1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 3'b001, 16'hFFFF, 16'hFFFF, 0, 1'b0, gotId, gotRes, gotErr);
      checkOutput("mul.lit_res", gotRes, 32'hFFFE_0001);
      checkOutput("mul.lit_id",  gotId,  32'h1);

      for (int k = 0; k < 4; k++) begin
         doOp("rr", 1'b1, 3'b010, 16'h0001, 16'h0002, 1'b1, 3'b101, 16'hA5A5, 16'h0F0F, 0, 1'b0, gotId, gotRes, gotErr);
         checkOutput("rr.lit_id",  gotId,  (k % 2 == 0) ? 32'h0 : 32'h1);
         checkOutput("rr.lit_res", gotRes, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_AAAA);
      end

      doOp("stall", 1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 3'b000, 16'h1234, 16'h1111, 5, 1'b1, gotId, gotRes, gotErr);
      checkOutput("stall.lit_res", gotRes, 32'h0000_2345);

      doOp("illegal", 1'b1, 3'b111, 16'hDEAD, 16'hBEEF, 1'b0, 3'b000, 16'h0, 16'h0, 1, 1'b0, gotId, gotRes, gotErr);
      checkOutput("illegal.lit_err", gotErr, 32'h1);
      checkOutput("illegal.lit_res", gotRes, 32'h0);

      doOp("not", 1'b1, 3'b110, 16'h00F0, 16'h1234, 1'b0, 3'b000, 16'h0, 16'h0, 0, 1'b0, gotId, gotRes, gotErr);
      checkOutput("not.lit_res", gotRes, 32'h0000_FF0F);

      // Reset landing in the middle of a MUL must discard it entirely
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 3'b001, 16'h0102, 16'h0304);
      tick();
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 3'b000, 16'h0, 16'h0);
      checkOutput("rstmid.busy_before", bus.busy, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mdlLastGrant = 1'b1;
      #1;
      checkResetState("rstmid");
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("rstmid.no_rsp", bus.rsp_valid, 32'h0);
      end
      doOp("post_rst", 1'b1, 3'b100, 16'h00F0, 16'h0F00, 1'b1, 3'b011, 16'hFFFF, 16'h00FF, 0, 1'b0, gotId, gotRes, gotErr);
      checkOutput("post_rst.lit_id",  gotId,  32'h0);
      checkOutput("post_rst.lit_res", gotRes, 32'h0000_0FF0);

      for (int k = 0; k < 40; k++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         doOp("rnd",
              v0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              v1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), gotId, gotRes, gotErr);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
